// File: rtl/gba_ds_pkg.sv
// Shared types and helpers for the multi-channel direct-sound engine.
// Channel FIFOs, the per-channel request FSM and the top-level timer muxing all use these.
package gba_ds_pkg;

  localparam int DS_SEL_MAX_W   = 8;
  localparam int VOL_HALF_SHIFT = 1;

  function automatic int ds_level_w(input int cap);
    return $clog2(cap) + 1;
  endfunction

  function automatic int ds_sel_w(input int num_timers);
    return (num_timers > 1) ? $clog2(num_timers) : 1;
  endfunction

  typedef struct packed {
    logic                    enable;
    logic                    vol_full;
    logic [DS_SEL_MAX_W-1:0] timer_sel;
  } ds_ch_cfg_t;

  typedef enum logic {
    REQ_IDLE        = 1'b0,
    REQ_WAIT_REFILL = 1'b1
  } req_state_t;

endpackage

// File: rtl/gba_ds_channel.sv
// One direct-sound PCM channel: byte FIFO fed by 32-bit words, timer-paced pop,
// DMA refill request handshake and volume-scaled registered sample output.
module gba_ds_channel
  import gba_ds_pkg::*;
#(
  parameter int FIFO_WORDS = 8,
  parameter int OUT_W      = 24,
  localparam int CAP       = 4 * FIFO_WORDS,
  localparam int PW        = $clog2(CAP),
  localparam int LW        = ds_level_w(CAP)
) (
  input  logic                    clk_100,
  input  logic                    reset_n,
  input  logic                    i_wr_en,
  input  logic [31:0]             i_wr_data,
  input  logic                    i_clr,
  input  logic                    i_tick,
  input  logic                    i_enable,
  input  logic                    i_vol_full,
  output logic                    o_req,
  output logic [LW-1:0]           o_level,
  output logic                    o_ovf,
  output logic signed [OUT_W-1:0] o_sample
);

  logic [7:0]              r_mem [CAP];
  logic [PW-1:0]           r_wr_ptr;
  logic [PW-1:0]           r_rd_ptr;
  logic [LW-1:0]           r_cnt;
  logic [LW-1:0]           w_cnt_nxt;
  logic [7:0]              r_byte;
  logic [7:0]              w_byte_nxt;
  logic signed [OUT_W-1:0] r_sample;
  logic                    r_ovf;
  logic                    r_req;
  logic                    w_accept;
  logic                    w_pop;
  logic                    w_trigger;
  req_state_t              r_state;
  req_state_t              w_state_nxt;

  function automatic logic signed [OUT_W-1:0] vol_scale(input logic [7:0] b, input logic full);
    logic signed [OUT_W-1:0] v;
    v = {b, {(OUT_W-8){1'b0}}};
    return full ? v : (v >>> VOL_HALF_SHIFT);
  endfunction

  // Acceptance looks at the pre-pop count, so a word is whole or dropped whole.
  assign w_accept   = i_wr_en && !i_clr && (r_cnt <= LW'(CAP - 4));
  assign w_pop      = i_tick && i_enable && !i_clr && (r_cnt != '0);
  assign w_cnt_nxt  = r_cnt + (w_accept ? LW'(4) : '0) - (w_pop ? LW'(1) : '0);
  assign w_byte_nxt = w_pop ? r_mem[r_rd_ptr] : r_byte;

  always_comb begin
    w_state_nxt = r_state;
    w_trigger   = 1'b0;
    case (r_state)
      REQ_IDLE: begin
        if (w_pop && (w_cnt_nxt <= LW'(CAP / 2))) begin
          w_trigger   = 1'b1;
          w_state_nxt = REQ_WAIT_REFILL;
        end
      end
      REQ_WAIT_REFILL: begin
        if (w_accept) w_state_nxt = REQ_IDLE;
      end
      default: w_state_nxt = REQ_IDLE;
    endcase
    if (i_clr) w_state_nxt = REQ_IDLE;
  end

  always_ff @(posedge clk_100 or negedge reset_n) begin
    if (!reset_n) r_state <= REQ_IDLE;
    else          r_state <= w_state_nxt;
  end

  always_ff @(posedge clk_100) begin
    if (w_accept) begin
      for (int k = 0; k < 4; k++) r_mem[r_wr_ptr + PW'(k)] <= i_wr_data[8*k +: 8];
    end
  end

  always_ff @(posedge clk_100 or negedge reset_n) begin
    if (!reset_n) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_cnt    <= '0;
      r_byte   <= '0;
      r_sample <= '0;
      r_ovf    <= 1'b0;
      r_req    <= 1'b0;
    end else if (i_clr) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_cnt    <= '0;
      r_byte   <= '0;
      r_sample <= '0;
      r_ovf    <= 1'b0;
      r_req    <= 1'b0;
    end else begin
      if (w_accept) r_wr_ptr <= r_wr_ptr + PW'(4);
      if (w_pop)    r_rd_ptr <= r_rd_ptr + PW'(1);
      if (i_wr_en && !w_accept) r_ovf <= 1'b1;
      r_cnt    <= w_cnt_nxt;
      r_byte   <= w_byte_nxt;
      r_sample <= i_enable ? vol_scale(w_byte_nxt, i_vol_full) : '0;
      r_req    <= w_trigger;
    end
  end

  assign o_req    = r_req;
  assign o_level  = r_cnt;
  assign o_ovf    = r_ovf;
  assign o_sample = r_sample;

endmodule

// File: rtl/gba_direct_sound_multi.sv
// Multi-channel direct-sound engine: routes the selected timer overflow to each
// channel and packs the per-channel status and samples onto flat ports.
module gba_direct_sound_multi
  import gba_ds_pkg::*;
#(
  parameter int NUM_CH     = 2,
  parameter int FIFO_WORDS = 8,
  parameter int NUM_TIMERS = 2,
  parameter int OUT_W      = 24,
  localparam int CAP       = 4 * FIFO_WORDS,
  localparam int LW        = ds_level_w(CAP),
  localparam int SW        = ds_sel_w(NUM_TIMERS)
) (
  input  logic                    clk_100,
  input  logic                    reset_n,
  input  logic [NUM_CH-1:0]       fifo_wr_en,
  input  logic [31:0]             fifo_wr_data,
  input  logic [NUM_CH-1:0]       fifo_clr,
  input  logic [NUM_CH-1:0]       ch_enable,
  input  logic [NUM_CH-1:0]       ch_vol_full,
  input  logic [NUM_CH*SW-1:0]    ch_timer_sel,
  input  logic [NUM_TIMERS-1:0]   timer_ovf,
  output logic [NUM_CH-1:0]       sound_req,
  output logic [NUM_CH*LW-1:0]    fifo_level,
  output logic [NUM_CH-1:0]       fifo_ovf,
  output logic [NUM_CH*OUT_W-1:0] sample_out
);

  ds_ch_cfg_t        w_cfg [NUM_CH];
  logic [NUM_CH-1:0] w_tick;

  // A select value with no matching timer leaves the tick low, so that channel never pops.
  always_comb begin
    for (int c = 0; c < NUM_CH; c++) begin
      w_cfg[c] = '{enable:    ch_enable[c],
                   vol_full:  ch_vol_full[c],
                   timer_sel: DS_SEL_MAX_W'(ch_timer_sel[c*SW +: SW])};
      w_tick[c] = 1'b0;
      for (int t = 0; t < NUM_TIMERS; t++) begin
        if (w_cfg[c].timer_sel == DS_SEL_MAX_W'(t)) w_tick[c] = timer_ovf[t];
      end
    end
  end

  for (genvar g = 0; g < NUM_CH; g++) begin : g_ch
    gba_ds_channel #(
      .FIFO_WORDS (FIFO_WORDS),
      .OUT_W      (OUT_W)
    ) u_ch (
      .clk_100    (clk_100),
      .reset_n    (reset_n),
      .i_wr_en    (fifo_wr_en[g]),
      .i_wr_data  (fifo_wr_data),
      .i_clr      (fifo_clr[g]),
      .i_tick     (w_tick[g]),
      .i_enable   (w_cfg[g].enable),
      .i_vol_full (w_cfg[g].vol_full),
      .o_req      (sound_req[g]),
      .o_level    (fifo_level[g*LW +: LW]),
      .o_ovf      (fifo_ovf[g]),
      .o_sample   (sample_out[g*OUT_W +: OUT_W])
    );
  end

endmodule

// File: tb/tb_gba_direct_sound_multi.sv
// Bench for gba_direct_sound_multi: queue-based channel model compared every cycle,
// directed scenarios with literal expectations, then randomized traffic.
module tb_gba_direct_sound_multi;

  localparam int NUM_CH     = 2;
  localparam int FIFO_WORDS = 8;
  localparam int NUM_TIMERS = 3;
  localparam int OUT_W      = 24;
  localparam int CAP        = 4 * FIFO_WORDS;
  localparam int LW         = $clog2(CAP) + 1;
  localparam int SW         = $clog2(NUM_TIMERS);

  logic                    clk_100 = 1'b0;
  logic                    reset_n;
  logic [NUM_CH-1:0]       fifo_wr_en;
  logic [31:0]             fifo_wr_data;
  logic [NUM_CH-1:0]       fifo_clr;
  logic [NUM_CH-1:0]       ch_enable;
  logic [NUM_CH-1:0]       ch_vol_full;
  logic [NUM_CH*SW-1:0]    ch_timer_sel;
  logic [NUM_TIMERS-1:0]   timer_ovf;
  logic [NUM_CH-1:0]       sound_req;
  logic [NUM_CH*LW-1:0]    fifo_level;
  logic [NUM_CH-1:0]       fifo_ovf;
  logic [NUM_CH*OUT_W-1:0] sample_out;

  gba_direct_sound_multi #(
    .NUM_CH     (NUM_CH),
    .FIFO_WORDS (FIFO_WORDS),
    .NUM_TIMERS (NUM_TIMERS),
    .OUT_W      (OUT_W)
  ) dut (
    .clk_100      (clk_100),
    .reset_n      (reset_n),
    .fifo_wr_en   (fifo_wr_en),
    .fifo_wr_data (fifo_wr_data),
    .fifo_clr     (fifo_clr),
    .ch_enable    (ch_enable),
    .ch_vol_full  (ch_vol_full),
    .ch_timer_sel (ch_timer_sel),
    .timer_ovf    (timer_ovf),
    .sound_req    (sound_req),
    .fifo_level   (fifo_level),
    .fifo_ovf     (fifo_ovf),
    .sample_out   (sample_out)
  );

  always #5 clk_100 = ~clk_100;

  int n_checks = 0;
  int n_errors = 0;

  task automatic check(input string name, input longint act, input longint exp);
    n_checks++;
    if (act != exp) begin
      n_errors++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  function automatic longint dut_sample(input int c);
    logic signed [OUT_W-1:0] v;
    v = sample_out[c*OUT_W +: OUT_W];
    return longint'(v);
  endfunction

  function automatic longint dut_level(input int c);
    return longint'(fifo_level[c*LW +: LW]);
  endfunction

  // Reference model: each FIFO is a byte queue; samples are plain integer arithmetic.
  typedef logic [7:0] bq_t [$];
  bq_t        mq       [NUM_CH];
  bit         m_ovf    [NUM_CH];
  bit         m_pend   [NUM_CH];
  bit         m_req    [NUM_CH];
  logic [7:0] m_byte   [NUM_CH];
  longint     m_sample [NUM_CH];

  function automatic longint scale(input logic [7:0] b, input bit full);
    longint v;
    v = longint'($signed(b)) * (longint'(1) << (OUT_W - 8));
    return full ? v : v / 2;
  endfunction

  always @(posedge clk_100 or negedge reset_n) begin
    int sel;
    int cnt;
    bit tick;
    bit pop;
    bit acc;
    if (!reset_n) begin
      for (int c = 0; c < NUM_CH; c++) begin
        mq[c].delete();
        m_ovf[c] = 0; m_pend[c] = 0; m_req[c] = 0; m_byte[c] = 8'h00; m_sample[c] = 0;
      end
    end else begin
      for (int c = 0; c < NUM_CH; c++) begin
        if (fifo_clr[c]) begin
          mq[c].delete();
          m_ovf[c] = 0; m_pend[c] = 0; m_req[c] = 0; m_byte[c] = 8'h00; m_sample[c] = 0;
        end else begin
          cnt  = mq[c].size();
          sel  = int'(ch_timer_sel[c*SW +: SW]);
          tick = (sel < NUM_TIMERS) ? timer_ovf[sel] : 1'b0;
          pop  = tick && ch_enable[c] && (cnt > 0);
          acc  = fifo_wr_en[c] && (cnt <= CAP - 4);
          if (fifo_wr_en[c] && !acc) m_ovf[c] = 1;
          if (pop) m_byte[c] = mq[c].pop_front();
          if (acc) for (int k = 0; k < 4; k++) mq[c].push_back(fifo_wr_data[8*k +: 8]);
          m_req[c] = 0;
          if (pop && !m_pend[c] && (mq[c].size() <= CAP / 2)) begin
            m_req[c]  = 1;
            m_pend[c] = 1;
          end else if (acc) begin
            m_pend[c] = 0;
          end
          m_sample[c] = ch_enable[c] ? scale(m_byte[c], ch_vol_full[c]) : 0;
        end
      end
    end
  end

  initial begin
    forever begin
      @(posedge clk_100);
      #1;
      for (int c = 0; c < NUM_CH; c++) begin
        check($sformatf("ch%0d_sample", c), dut_sample(c), m_sample[c]);
        check($sformatf("ch%0d_level", c), dut_level(c), longint'(mq[c].size()));
        check($sformatf("ch%0d_ovf", c), longint'(fifo_ovf[c]), longint'(m_ovf[c]));
        check($sformatf("ch%0d_req", c), longint'(sound_req[c]), longint'(m_req[c]));
      end
    end
  end

  task automatic idle();
    @(negedge clk_100);
  endtask

  task automatic wr(input int c, input logic [31:0] d);
    fifo_wr_en[c] = 1'b1;
    fifo_wr_data  = d;
    @(negedge clk_100);
    fifo_wr_en = '0;
  endtask

  task automatic tmr(input int t);
    timer_ovf[t] = 1'b1;
    @(negedge clk_100);
    timer_ovf = '0;
  endtask

  task automatic clr(input int c);
    fifo_clr[c] = 1'b1;
    @(negedge clk_100);
    fifo_clr = '0;
  endtask

  initial begin
    int nreq;
    reset_n      = 1'b0;
    fifo_wr_en   = '0;
    fifo_wr_data = '0;
    fifo_clr     = '0;
    ch_enable    = '1;
    ch_vol_full  = '1;
    ch_timer_sel = {2'd1, 2'd0};
    timer_ovf    = '0;
    repeat (3) @(negedge clk_100);
    check("rst_level", longint'(fifo_level), 0);
    check("rst_sample", longint'(sample_out), 0);
    check("rst_req_ovf", longint'({sound_req, fifo_ovf}), 0);
    reset_n = 1'b1;
    idle();

    // Basic byte order and full-volume scaling.
    wr(0, 32'h04030201);
    check("t1_level_after_write", dut_level(0), 4);
    for (int k = 1; k <= 4; k++) begin
      tmr(0);
      check($sformatf("t1_sample_pop%0d", k), dut_sample(0), longint'(k) * 65536);
      check($sformatf("t1_level_pop%0d", k), dut_level(0), 4 - k);
    end

    // Overflow drops the whole word; clear resets level and flag.
    clr(0);
    for (int i = 0; i < 8; i++) wr(0, $urandom);
    check("t2_level_full", dut_level(0), 32);
    wr(0, 32'hDEADBEEF);
    check("t2_level_after_drop", dut_level(0), 32);
    check("t2_ovf_set", longint'(fifo_ovf[0]), 1);
    clr(0);
    check("t2_level_clr", dut_level(0), 0);
    check("t2_ovf_clr", longint'(fifo_ovf[0]), 0);

    // Request handshake: one pulse per refill.
    for (int i = 0; i < 8; i++) wr(0, $urandom);
    nreq = 0;
    for (int i = 0; i < 15; i++) begin
      tmr(0);
      nreq += int'(sound_req[0]);
    end
    check("t3_no_req_first15", nreq, 0);
    tmr(0);
    check("t3_level_16", dut_level(0), 16);
    check("t3_req_at_16", longint'(sound_req[0]), 1);
    idle();
    check("t3_req_one_cycle", longint'(sound_req[0]), 0);
    tmr(0);
    check("t3_no_req_pending", longint'(sound_req[0]), 0);
    wr(0, $urandom);
    tmr(0);
    check("t3_no_req_18", longint'(sound_req[0]), 0);
    tmr(0);
    check("t3_no_req_17", longint'(sound_req[0]), 0);
    tmr(0);
    check("t3_rearm_req", longint'(sound_req[0]), 1);

    // Half volume of a negative byte, then volume change without a pop.
    clr(0);
    wr(0, 32'h00000080);
    ch_vol_full[0] = 1'b0;
    tmr(0);
    check("t4_half_80", longint'(sample_out[OUT_W-1:0]), longint'(24'hC00000));
    ch_vol_full[0] = 1'b1;
    idle();
    check("t4_full_80", longint'(sample_out[OUT_W-1:0]), longint'(24'h800000));

    // Simultaneous write and pop.
    clr(0);
    for (int i = 0; i < 7; i++) wr(0, $urandom);
    fifo_wr_en[0] = 1'b1; fifo_wr_data = $urandom; timer_ovf[0] = 1'b1;
    idle();
    fifo_wr_en = '0; timer_ovf = '0;
    check("t5_level_31", dut_level(0), 31);
    tmr(0);
    tmr(0);
    check("t5_level_29", dut_level(0), 29);
    fifo_wr_en[0] = 1'b1; fifo_wr_data = $urandom; timer_ovf[0] = 1'b1;
    idle();
    fifo_wr_en = '0; timer_ovf = '0;
    check("t5_level_28", dut_level(0), 28);
    check("t5_ovf", longint'(fifo_ovf[0]), 1);

    // Channel independence and an out-of-range timer select.
    clr(0);
    clr(1);
    fifo_wr_en = '1; fifo_wr_data = 32'h7F7F7F7F;
    idle();
    fifo_wr_en = '0;
    tmr(1);
    check("t6_ch0_untouched", dut_level(0), 4);
    check("t6_ch1_popped", dut_level(1), 3);
    check("t6_ch1_sample", dut_sample(1), longint'(127) * 65536);
    ch_timer_sel[2*SW-1:SW] = 2'd3;
    timer_ovf = '1;
    idle();
    timer_ovf = '0;
    check("t6_ch1_no_timer", dut_level(1), 3);
    check("t6_ch0_popped", dut_level(0), 3);
    ch_timer_sel[2*SW-1:SW] = 2'd1;

    // Asynchronous reset mid-stream.
    wr(1, 32'h11111111);
    #2 reset_n = 1'b0;
    #1;
    check("t7_async_level", longint'(fifo_level), 0);
    check("t7_async_sample", longint'(sample_out), 0);
    check("t7_async_req_ovf", longint'({sound_req, fifo_ovf}), 0);
    idle();
    reset_n = 1'b1;
    idle();

    // Randomized traffic against the model.
    for (int i = 0; i < 4000; i++) begin
      for (int c = 0; c < NUM_CH; c++) begin
        fifo_wr_en[c]  = ((i / 400) % 2 == 0) ? ($urandom_range(0, 3) == 0) : ($urandom_range(0, 9) == 0);
        fifo_clr[c]    = ($urandom_range(0, 199) == 0);
        ch_enable[c]   = ($urandom_range(0, 9) != 0);
        ch_vol_full[c] = ($urandom_range(0, 1) == 1);
      end
      fifo_wr_data = $urandom;
      if ($urandom_range(0, 49) == 0) ch_timer_sel = (NUM_CH*SW)'($urandom);
      timer_ovf = NUM_TIMERS'($urandom);
      idle();
    end
    fifo_wr_en = '0;
    fifo_clr   = '0;
    timer_ovf  = '0;
    repeat (3) idle();

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
